// File: rtl/debug_pkg.sv
// ---------------------------------------------------------------------------
// debug_pkg : shared types and constants for the UART debug logger front end
// Optional: PROBE_CAPTURE_TIMESTAMP_EN adds the timestamped entry type.
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package debug_pkg;

  localparam int DROP_CNT_WIDTH  = 16;
  localparam int TS_WIDTH_DEF    = 16;
  localparam int PROBE_WIDTH_DEF = 32;

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;

  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0]    ts;
    logic [PROBE_WIDTH_DEF-1:0] probe;
  } ts_entry_t;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } capture_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft : first-word-fall-through FIFO with registered level
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo_fwft
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   level_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q,  level_d;

  // Pointer MSB is a lap bit: equal index with differing lap means full.
  assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  assign rd_data_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o      = level_q;
  assign level_next_o = level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + LW'(1);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + LW'(1);
      if (wr_en_i && !rd_en_i)      level_d = level_q + LW'(1);
      else if (!wr_en_i && rd_en_i) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/probe_capture_fifo.sv
// ---------------------------------------------------------------------------
// probe_capture_fifo : trigger edge detect, decimation, capture FIFO, handshake
// Optional macro     : PROBE_CAPTURE_TIMESTAMP_EN (prefix words with timestamp)
// Revision           : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module probe_capture_fifo
  import debug_pkg::*;
#(
  parameter int PROBE_WIDTH = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int DECIM_WIDTH = 8,
  parameter int TS_WIDTH    = 16,
  localparam int OUT_WIDTH  = PROBE_WIDTH + (TS_EN ? TS_WIDTH : 0),
  localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [PROBE_WIDTH-1:0]    debug_probe_i,
  input  logic                      debug_trig_i,
  input  logic [DECIM_WIDTH-1:0]    decim_i,
  input  logic                      flush_i,
  output logic [OUT_WIDTH-1:0]      out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LVL_WIDTH-1:0]      fill_level_o,
  output logic                      overflow_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_count_o
);

  logic                      trig_q;
  logic [DECIM_WIDTH-1:0]    decim_cnt_q, decim_cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      ovf_q, ovf_d;
  capture_state_t            state_q, state_d;

  logic                      w_rise, w_capture, w_pop, w_push, w_drop, w_valid;
  logic                      w_full, w_empty;
  logic [OUT_WIDTH-1:0]      w_wr_data, w_rd_data;
  logic [LVL_WIDTH-1:0]      w_level, w_level_next;

  assign w_rise    = debug_trig_i & ~trig_q;
  assign w_capture = w_rise & (decim_cnt_q == '0) & ~flush_i;
  assign w_pop     = w_valid & out_ready_i & ~w_empty & ~flush_i;
  // A full FIFO still accepts the capture when the head leaves this cycle.
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ts_q <= '0;
    else          ts_q <= ts_q + TS_WIDTH'(1);
  end

  assign w_wr_data = {ts_q, debug_probe_i};
`else
  assign w_wr_data = debug_probe_i;
`endif

  always_comb begin
    decim_cnt_d = decim_cnt_q;
    if (flush_i) begin
      decim_cnt_d = '0;
    end else if (w_rise) begin
      if (decim_i <= DECIM_WIDTH'(1) || decim_cnt_q >= decim_i - DECIM_WIDTH'(1))
        decim_cnt_d = '0;
      else
        decim_cnt_d = decim_cnt_q + DECIM_WIDTH'(1);
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (flush_i) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (w_drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      trig_q      <= 1'b0;
      decim_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      trig_q      <= debug_trig_i;
      decim_cnt_q <= decim_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo_fwft #(
    .DATA_WIDTH (OUT_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .clr_i        (flush_i),
    .wr_en_i      (w_push),
    .wr_data_i    (w_wr_data),
    .rd_en_i      (w_pop),
    .rd_data_o    (w_rd_data),
    .full_o       (w_full),
    .empty_o      (w_empty),
    .level_o      (w_level),
    .level_next_o (w_level_next)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Steering on the next level lets a push into an empty FIFO show valid one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (w_level_next != '0) state_d = HOLD;
      HOLD:    if (w_level_next == '0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_comb begin
    w_valid    = (state_q == HOLD);
    out_valid_o = w_valid;
    out_data_o  = w_valid ? w_rd_data : '0;
  end

  assign fill_level_o = w_level;
  assign overflow_o   = ovf_q;
  assign drop_count_o = drop_cnt_q;

endmodule

`default_nettype wire
